temporal_frame_window: RTL and testbench
========================================

// Module: temporal_frame_window
// PURPOSE
//  Producer side of the temporal-derivative pixel bus. Accepts a raster pixel stream.
//  Stores the last NUM_FRAMES-1 frames in on-chip RAM. For every accepted pixel it emits
//  the same (x,y) location across NUM_FRAMES consecutive frames, packed on one bus.
//  That bus feeds temporal_derivative_calc pixels_in/en directly.
// PARAMETERS
//  PIXEL_WIDTH  8            bits per pixel
//  NUM_FRAMES   7            frames per output vector (3 derivative frames + 5-tap kernel - 1)
//  IMG_WIDTH    64           pixels per line
//  IMG_HEIGHT   48           lines per frame
//  NUM_PIXELS   IMG_WIDTH*IMG_HEIGHT   derived; pixel addresses 0..NUM_PIXELS-1
//  ADDR_BITS    $clog2(NUM_PIXELS)     derived
//  M            NUM_FRAMES-1           derived; number of stored frame slots
// PORTS
//  clk           in   1                       system clock, all logic on rising edge
//  rst_n         in   1                       asynchronous active-low reset
//  pixel_in      in   PIXEL_WIDTH             incoming pixel, unsigned
//  pixel_valid   in   1                       pixel_in valid this cycle; no backpressure
//  frame_start   in   1                       first pixel of a frame; only sampled with pixel_valid
//  pixels_out    out  PIXEL_WIDTH*NUM_FRAMES  slice k = frame k-ago (k=0 current, k=M oldest)
//  out_valid     out  1                       pixels_out valid; drives consumer en
//  window_ready  out  1                       high once M complete frames are stored
//  overflow      out  1                       sticky: pixel dropped past NUM_PIXELS-1 in a frame
// BEHAVIOUR
//  Reset: pixels_out=0, out_valid=0, window_ready=0, overflow=0.
//   Reset also clears addr=0, wr_slot=0, frame_cnt=0 and state=FILL. RAM is not cleared.
//  Storage: M slots x NUM_PIXELS words. Slot (wr_slot-k) mod M holds frame k-ago, k=1..M.
//   The current frame is written into wr_slot, which is also the oldest frame (k=M).
//  Accept (pixel_valid=1):
//   - If frame_start=1, the effective address is 0.
//     If frame_cnt>0 or addr>0, wr_slot advances (+1 mod M) before the access.
//     frame_cnt increments, saturating at M.
//   - Otherwise the effective address is addr.
//   - All M slots are read at the effective address. The RAM is read-first: reading wr_slot
//     returns the old (k=M) data, then pixel_in is written there.
//   - addr = effective address + 1.
//   - If the effective address is >= NUM_PIXELS, the pixel is dropped: no write, no output,
//     overflow is set, and addr does not advance.
//  States:
//   - FILL -> RUN when frame_cnt reaches M on a frame_start.
//   - RUN holds until reset. window_ready = (state==RUN).
//  Output:
//   - An accepted, non-dropped pixel in RUN at cycle T gives out_valid=1 at T+2.
//     Pipeline: RAM read register, then output pack register.
//   - pixel_in is delayed 2 cycles to align it into slice 0.
//   - In FILL, out_valid=0. pixels_out holds its last value whenever out_valid=0.
//  Boundaries:
//   - Short frame (frame_start before NUM_PIXELS pixels): counted as complete.
//     Unwritten locations keep stale data.
//   - pixel_valid=0 cycles: no state change. Gaps are allowed anywhere.
//   - frame_start without pixel_valid: ignored.
//   - Back-to-back frame_start pixels: each is a 1-pixel frame.
//   - Mid-operation reset: in-flight outputs are discarded. M full frames must refill
//     before out_valid returns.
// TESTING (bench params: PIXEL_WIDTH=8, NUM_FRAMES=3, IMG_WIDTH=4, IMG_HEIGHT=2)
//  1 Reset held, random inputs -> all outputs 0; release -> out_valid stays 0 through frames 0,1.
//  2 Frames f=0,1,2 with pixel=16f+addr -> frame 2 addr 3 gives pixels_out={8'h03,8'h13,8'h23}
//    at T+2, with slice 0 = 8'h23. window_ready rises on the frame-2 frame_start.
//  3 Continuous 6 frames, random pixel_valid gaps -> every output equals a reference circular model.
//    Exactly 8 out_valid pulses per frame from frame 2 on; latency is always 2.
//  4 Frame 1 cut to 5 pixels, then frame_start -> frame 2 addr 6 slice 1 = stale frame-0 data (8'h06).
//    Counting is unaffected.
//  5 Frame of 10 pixels -> pixels 9,10 dropped, overflow=1 sticky, addr=8.
//    The next frame_start restarts at 0.
//  6 rst_n pulse mid-frame 3 -> out_valid=0 within 1 cycle.
//    The next 2 full frames give no output; the 3rd frame gives output.

Source files
------------

// File: rtl/temporal_frame_window.sv
// temporal_frame_window
// Producer side of the temporal-derivative pixel bus. Stores the last NUM_FRAMES-1
// frames in on-chip RAM and, for every accepted raster pixel, emits that (x,y)
// location from NUM_FRAMES consecutive frames on one packed bus (slice 0 = current
// frame, slice NUM_FRAMES-1 = oldest). Two-cycle latency: RAM read register, then
// the output pack register.
module temporal_frame_window #(
  parameter int PIXEL_WIDTH = 8,
  parameter int NUM_FRAMES  = 7,
  parameter int IMG_WIDTH   = 64,
  parameter int IMG_HEIGHT  = 48
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PIXEL_WIDTH-1:0]            pixel_in,
  input  logic                              pixel_valid,
  input  logic                              frame_start,
  output logic [PIXEL_WIDTH*NUM_FRAMES-1:0] pixels_out,
  output logic                              out_valid,
  output logic                              window_ready,
  output logic                              overflow
);

  localparam int NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_BITS  = $clog2(NUM_PIXELS);
  localparam int M          = NUM_FRAMES - 1;
  localparam int SLOT_BITS  = (M > 1) ? $clog2(M) : 1;
  localparam int CNT_BITS   = $clog2(M + 1);
  // One extra address bit so the "one past the end" address is representable.
  localparam int AW         = ADDR_BITS + 1;
  localparam int PW         = PIXEL_WIDTH;

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [AW-1:0]          r_addr;
  logic [SLOT_BITS-1:0]   r_wr_slot;
  logic [CNT_BITS-1:0]    r_frame_cnt;
  logic                   r_overflow;

  logic                   r_v1;
  logic [SLOT_BITS-1:0]   r_slot1;
  logic [PW-1:0]          r_pix1;
  logic                   r_out_valid;
  logic [PW*NUM_FRAMES-1:0] r_pixels_out;

  logic                   w_fs;
  logic [AW-1:0]          w_eff_addr;
  logic [ADDR_BITS-1:0]   w_ram_addr;
  logic [SLOT_BITS-1:0]   w_slot_inc;
  logic [SLOT_BITS-1:0]   w_slot;
  logic                   w_cnt_full;
  logic                   w_drop;
  logic                   w_write;
  logic [PW*M-1:0]        w_rd_flat;
  logic [PW*NUM_FRAMES-1:0] w_pack;

  // A frame_start pixel restarts at address 0; the very first frame after reset
  // (nothing counted, nothing written) stays in slot 0 instead of advancing.
  assign w_fs       = pixel_valid & frame_start;
  assign w_eff_addr = w_fs ? '0 : r_addr;
  assign w_ram_addr = w_eff_addr[ADDR_BITS-1:0];
  assign w_slot_inc = (r_wr_slot == SLOT_BITS'(M - 1)) ? '0 : r_wr_slot + SLOT_BITS'(1);
  assign w_slot     = (w_fs && (r_frame_cnt != '0 || r_addr != '0)) ? w_slot_inc : r_wr_slot;
  assign w_cnt_full = (r_frame_cnt == CNT_BITS'(M));
  assign w_drop     = pixel_valid && (w_eff_addr >= AW'(NUM_PIXELS));
  assign w_write    = pixel_valid && !w_drop;

  // Window state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_state_next;
  end

  // Enter RUN on the frame_start that follows M counted frames; RUN is held
  always_comb begin
    w_state_next = r_state;
    if (r_state == S_FILL && w_fs && w_cnt_full) w_state_next = S_RUN;
  end

  // Write-side bookkeeping: address, slot rotation, frame count, overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wr_slot   <= '0;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
    end else if (pixel_valid) begin
      if (w_fs) begin
        r_wr_slot <= w_slot;
        if (!w_cnt_full) r_frame_cnt <= r_frame_cnt + CNT_BITS'(1);
      end
      if (w_drop) r_overflow <= 1'b1;
      else        r_addr     <= w_eff_addr + AW'(1);
    end
  end

  // Frame slots: read-first RAMs, all read at the same address each accept
  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_slot
      logic [PW-1:0] r_mem [NUM_PIXELS];
      logic [PW-1:0] r_rd;
      // Registered read of the old word, then write into the active slot
      always_ff @(posedge clk) begin
        if (w_write) begin
          r_rd <= r_mem[w_ram_addr];
          if (w_slot == SLOT_BITS'(gi)) r_mem[w_ram_addr] <= pixel_in;
        end
      end
      assign w_rd_flat[gi*PW +: PW] = r_rd;
    end
  endgenerate

  // Map physical slots to frame age: slice k comes from slot (wr_slot - k) mod M,
  // and slice M is the active slot itself (its pre-write contents).
  assign w_pack[PW-1:0] = r_pix1;
  generate
    for (gi = 1; gi <= M; gi++) begin : g_pack
      logic [SLOT_BITS-1:0] w_src;
      assign w_src = (r_slot1 >= SLOT_BITS'(gi)) ? r_slot1 - SLOT_BITS'(gi)
                                                 : r_slot1 + SLOT_BITS'(M - gi);
      assign w_pack[gi*PW +: PW] = w_rd_flat[w_src*PW +: PW];
    end
  endgenerate

  // Two-stage output pipeline; the pack register holds while no output is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1         <= 1'b0;
      r_slot1      <= '0;
      r_pix1       <= '0;
      r_out_valid  <= 1'b0;
      r_pixels_out <= '0;
    end else begin
      r_v1        <= w_write && (w_state_next == S_RUN);
      r_slot1     <= w_slot;
      r_pix1      <= pixel_in;
      r_out_valid <= r_v1;
      if (r_v1) r_pixels_out <= w_pack;
    end
  end

  assign pixels_out   = r_pixels_out;
  assign out_valid    = r_out_valid;
  assign window_ready = (r_state == S_RUN);
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_temporal_frame_window.sv
// Bench for temporal_frame_window: stimulus pushes expected output vectors into a
// queue, a negedge monitor pops and compares them whenever out_valid is high.
module tb_temporal_frame_window;

  localparam int PW = 8;
  localparam int NF = 3;
  localparam int IW = 4;
  localparam int IH = 2;
  localparam int M  = NF - 1;
  localparam int NP = IW * IH;
  localparam int OW = PW * NF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] pixel_in;
  logic          pixel_valid;
  logic          frame_start;
  logic [OW-1:0] pixels_out;
  logic          out_valid;
  logic          window_ready;
  logic          overflow;

  temporal_frame_window #(
    .PIXEL_WIDTH(PW), .NUM_FRAMES(NF), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .pixels_out(pixels_out), .out_valid(out_valid),
    .window_ready(window_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    int            due;
    int            tag;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            checks   = 0;
  int            failures = 0;
  int            cyc_cnt  = 0;
  int            n_out    = 0;
  logic [OW-1:0] cap [0:7];

  // Reference storage: physical slots, slot (slot-k) mod M holds frame k-ago.
  logic [PW-1:0] mm [M][NP];
  int            m_slot, m_cnt, m_addr;
  bit            m_run, m_ovf;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid output must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      n_out++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%0h required=no_output", pixels_out);
      end else begin
        mon_e = q.pop_front();
        chk("pixels_out", pixels_out, mon_e.data);
        chk("latency_cycle", cyc_cnt, mon_e.due);
        if (mon_e.tag > 0) cap[mon_e.tag] = pixels_out;
      end
    end
  end

  task automatic model_reset();
    q.delete();
    m_slot = 0; m_cnt = 0; m_addr = 0; m_run = 0; m_ovf = 0;
  endtask

  // One input cycle: drive, update the reference, queue any expected output
  task automatic step(input logic v, input logic fs, input logic [PW-1:0] p, input int tag);
    int            ea;
    logic [OW-1:0] ex;
    exp_t          e;
    pixel_valid = v; frame_start = fs; pixel_in = p;
    if (v) begin
      if (fs) begin
        ea = 0;
        if (m_cnt > 0 || m_addr > 0) m_slot = (m_slot + 1) % M;
        if (m_cnt == M) m_run = 1;
        else            m_cnt++;
      end else begin
        ea = m_addr;
      end
      if (ea >= NP) begin
        m_ovf = 1;
      end else begin
        ex[PW-1:0] = p;
        for (int k = 1; k <= M; k++) ex[k*PW +: PW] = mm[(m_slot - k + M) % M][ea];
        mm[m_slot][ea] = p;
        m_addr = ea + 1;
        if (m_run) begin
          e.data = ex; e.due = cyc_cnt + 2; e.tag = tag;
          q.push_back(e);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 8'($urandom), 0);
  endtask

  task automatic frame(input logic [PW-1:0] base, input int npix, input bit rnd,
                       input int gapmax, input int tag_addr, input int tag);
    logic [PW-1:0] p;
    for (int a = 0; a < npix; a++) begin
      p = rnd ? 8'($urandom) : base + 8'(a);
      step(1'b1, a == 0, p, (a == tag_addr) ? tag : 0);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
    idle(3);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; pixel_valid = 1'b0; frame_start = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n = 1'b0; pixel_valid = 1'b0; frame_start = 1'b0; pixel_in = '0;
    model_reset();

    // 1: reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      pixel_valid = 1'($urandom); frame_start = 1'($urandom); pixel_in = 8'($urandom);
      @(posedge clk); #1;
      chk("reset_outputs", {pixels_out, out_valid, window_ready, overflow}, '0);
    end
    rst_n = 1'b1; pixel_valid = 1'b0;
    @(posedge clk); #1;

    // 1/2: frames 0,1 give nothing, frame 2 starts the window
    frame(8'h00, NP, 0, 0, -1, 0);
    frame(8'h10, NP, 0, 0, -1, 0);
    chk("fill_no_output", n_out, 0);
    chk("ready_before_f2", window_ready, 0);
    step(1'b1, 1'b1, 8'h20, 0);
    chk("ready_after_f2_start", window_ready, 1);
    for (int a = 1; a < NP; a++) step(1'b1, 1'b0, 8'h20 + 8'(a), (a == 3) ? 1 : 0);
    idle(3);
    chk("f2_addr3_vector", cap[1], 24'h031323);
    chk("f2_output_count", n_out, NP);

    // 3: six frames with random data and random valid gaps
    do_reset(2);
    for (int f = 0; f < 6; f++) begin
      n0 = n_out;
      frame(8'h00, NP, 1, 2, -1, 0);
      chk("gap_frame_count", n_out - n0, (f >= 2) ? NP : 0);
    end

    // 4: short frame leaves stale data in its slot
    do_reset(2);
    frame(8'h40, NP, 0, 0, -1, 0);
    frame(8'h00, NP, 0, 0, -1, 0);
    do_reset(2);
    frame(8'h00, NP, 0, 0, -1, 0);
    frame(8'h10, 5, 0, 0, -1, 0);
    n0 = n_out;
    frame(8'h20, NP, 0, 0, 6, 2);
    chk("short_frame_stale", cap[2], 24'h060626);
    chk("short_frame_ready", window_ready, 1);
    chk("short_frame_count", n_out - n0, NP);

    // 5: overlong frame drops the excess pixels and sets sticky overflow
    chk("overflow_clear", overflow, 0);
    n0 = n_out;
    frame(8'h30, NP + 2, 0, 0, -1, 0);
    chk("overflow_count", n_out - n0, NP);
    chk("overflow_set", overflow, 1);
    frame(8'h40, NP, 0, 0, 0, 3);
    chk("restart_after_overflow", cap[3], 24'h203040);
    chk("overflow_sticky", overflow, 1);

    // 6: reset in the middle of a running frame
    frame(8'h50, NP, 0, 0, -1, 0);
    step(1'b1, 1'b1, 8'h60, 0);
    step(1'b1, 1'b0, 8'h61, 0);
    step(1'b1, 1'b0, 8'h62, 0);
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_kills_valid", out_valid, 0);
    chk("reset_clears_out", pixels_out, '0);
    do_reset(2);
    for (int a = 3; a < NP; a++) step(1'b1, 1'b0, 8'h60 + 8'(a), 0);
    idle(3);
    n0 = n_out;
    frame(8'h70, NP, 0, 0, -1, 0);
    frame(8'h80, NP, 0, 0, -1, 0);
    chk("refill_no_output", n_out - n0, 0);
    chk("refill_not_ready", window_ready, 0);
    n0 = n_out;
    frame(8'h90, NP, 0, 0, -1, 0);
    chk("refill_output", n_out - n0, NP);

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
